// File: rtl/kb_pkg.sv
// Shared constants, parser state and decoded-event types for the PS/2 key tracker.
package kb_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_BAT  = 8'hAA;
  localparam logic [7:0] SC_ACK  = 8'hFA;
  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERR1 = 8'hFF;
  localparam logic [7:0] SC_NAK  = 8'hFC;
  localparam logic [7:0] SC_RES  = 8'hFE;

  typedef enum logic [1:0] {
    PS_IDLE    = 2'd0,
    PS_EXT     = 2'd1,
    PS_BRK     = 2'd2,
    PS_EXT_BRK = 2'd3
  } kb_parse_t;

  typedef struct packed {
    logic       valid;
    logic       make;
    logic       ext;
    logic [7:0] code;
  } kb_evt_t;

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_NAK) || (b == SC_RES);
  endfunction

  function automatic logic is_overrun(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/kb_scan_parser.sv
// Set-2 prefix parser: turns raw scan bytes into registered make/break events,
// flags overrun bytes and abandons a prefix that waits too long for its next byte.
module kb_scan_parser
  import kb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_new,
  input  logic [7:0] scan_byte,
  output kb_evt_t    evt,
  output logic       overrun,
  output logic       rx_error
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  kb_parse_t        state_q, state_d;
  kb_evt_t          evt_d;
  logic             ovr_d, err_d, tmo_hit;
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state_q != PS_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // NOTE: every output of an always_comb gets a default first; a path that skips an assignment infers a latch.
  always_comb begin
    state_d = state_q;
    evt_d   = '0;
    ovr_d   = 1'b0;
    err_d   = 1'b0;
    if (code_new) begin
      if (is_overrun(scan_byte)) begin
        state_d = PS_IDLE;
        ovr_d   = 1'b1;
        err_d   = 1'b1;
      end else if (is_ctrl(scan_byte)) begin
        state_d = PS_IDLE;
      end else begin
        unique case (state_q)
          PS_IDLE: begin
            if (scan_byte == SC_EXT)      state_d = PS_EXT;
            else if (scan_byte == SC_BRK) state_d = PS_BRK;
            else evt_d = '{valid: 1'b1, make: 1'b1, ext: 1'b0, code: scan_byte};
          end
          PS_EXT: begin
            if (scan_byte == SC_BRK)      state_d = PS_EXT_BRK;
            else if (scan_byte != SC_EXT) begin
              evt_d   = '{valid: 1'b1, make: 1'b1, ext: 1'b1, code: scan_byte};
              state_d = PS_IDLE;
            end
          end
          PS_BRK: begin
            evt_d   = '{valid: 1'b1, make: 1'b0, ext: 1'b0, code: scan_byte};
            state_d = PS_IDLE;
          end
          PS_EXT_BRK: begin
            evt_d   = '{valid: 1'b1, make: 1'b0, ext: 1'b1, code: scan_byte};
            state_d = PS_IDLE;
          end
          default: state_d = PS_IDLE;
        endcase
      end
    end else if (tmo_hit) begin
      state_d = PS_IDLE;
      err_d   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PS_IDLE;
      evt      <= '0;
      overrun  <= 1'b0;
      rx_error <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      evt      <= evt_d;
      overrun  <= ovr_d;
      rx_error <= err_d;
      if (code_new || state_q == PS_IDLE || tmo_hit) tmo_cnt <= '0;
      else                                           tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kb_key_tracker.sv
// PS/2 key tracker: matches parsed events against KEY_CODES and drives held state and edge pulses.
// Define KB_LONG_PRESS_EN to add per-key hold counters driving key_long.
module kb_key_tracker
  import kb_pkg::*;
#(
  parameter int unsigned           NUM_KEYS    = 8,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES   = {9'h174, 9'h16B, 9'h172, 9'h175,
                                                  9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int unsigned           TIMEOUT_CYC = 200000,
  parameter int unsigned           LONG_CYC    = 50000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                code_new,
  input  logic [7:0]          scan_byte,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_pressed,
  output logic [NUM_KEYS-1:0] key_long,
  output logic                rx_error
);

  kb_evt_t             evt;
  logic                overrun;
  logic [NUM_KEYS-1:0] state_d;

  kb_scan_parser #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_parser (
    .clk       (clk),
    .rst_n     (rst_n),
    .code_new  (code_new),
    .scan_byte (scan_byte),
    .evt       (evt),
    .overrun   (overrun),
    .rx_error  (rx_error)
  );

  // Every matching entry follows the event, so duplicated codes move together.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (evt.valid && KEY_CODES[9*i +: 9] == {evt.ext, evt.code}) state_d[i] = evt.make;
      else                                                         state_d[i] = key_state[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      any_pressed <= 1'b0;
    end else begin
      any_pressed <= |key_state;
      if (overrun) begin
        // Lost bytes leave the true key state unknown: drop everything silently.
        key_state   <= '0;
        key_press   <= '0;
        key_release <= '0;
      end else begin
        key_state   <= state_d;
        key_press   <= state_d & ~key_state;
        key_release <= ~state_d & key_state;
      end
    end
  end

`ifdef KB_LONG_PRESS_EN
  localparam int unsigned LONG_W = $clog2(LONG_CYC + 1);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_long
    logic [LONG_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 hold_cnt <= '0;
      else if (!key_state[i])                     hold_cnt <= '0;
      else if (hold_cnt != LONG_W'(LONG_CYC))     hold_cnt <= hold_cnt + 1'b1;
    end

    assign key_long[i] = key_state[i] && (hold_cnt == LONG_W'(LONG_CYC));
  end
`else
  assign key_long = '0;
`endif

endmodule
